io_port_buffer: RTL

- Memory-mapped I/O endpoint on the CPU's byte-wide memory port, active when mem_a[17:16]==2'b11.
- Buffers output bytes in a FIFO that drains to the UART transmitter, and drives io_buffer_full back to the CPU.
- Returns the input byte and the cycle counter on reads.
- Raises sim_done once a program-stop write has fully drained.

---
 rtl/io_port_buffer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/io_port_buffer.sv
// Memory-mapped I/O endpoint: TX byte FIFO toward the UART, RX holding byte, cycle counter readback.
// Latency: a write reaches tx_valid one cycle later; read data appears one cycle after the access.
// Backpressure: io_buffer_full warns the CPU early; tx_ready stalls the FIFO head; full-FIFO writes drop.
module io_port_buffer #(
    parameter int DEPTH_LOG   = 4,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  io_din,
    output logic        io_rd_sel,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        sim_done,
    output logic        tx_overflow
);

    localparam int                 DEPTH   = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] PTR_ONE = 1;

    // Bus decode: the endpoint owns the 0x3xxxx window, offsets come from the low address bits.
    logic       sel;
    logic       acc;
    logic [2:0] off;
    logic       rd;
    logic       unused_addr;

    assign sel         = (mem_a[17:16] == 2'b11);
    assign acc         = rdy_in & sel;
    assign off         = mem_a[2:0];
    assign rd          = acc & ~mem_wr;
    assign unused_addr = ^{mem_a[31:18], mem_a[15:3]};

    // TX FIFO storage and pointers; the extra pointer MSB tells full from empty.
    logic [7:0]         mem [DEPTH];
    logic [DEPTH_LOG:0] wptr;
    logic [DEPTH_LOG:0] rptr;
    logic [DEPTH_LOG:0] count;
    logic [DEPTH_LOG:0] next_count;
    logic               empty;
    logic               full;
    logic               wr_req;
    logic               stop_wr;
    logic [7:0]         push_byte;
    logic               push;
    logic               pop;
    logic               drop;
    logic               full_next;

    assign empty = (wptr == rptr);
    assign full  = (wptr[DEPTH_LOG] != rptr[DEPTH_LOG]) &&
                   (wptr[DEPTH_LOG-1:0] == rptr[DEPTH_LOG-1:0]);

    // Offset 0 filters NUL bytes; offset 4 is the program-stop marker and always enqueues 0x00.
    assign stop_wr   = acc & mem_wr & (off == 3'd4);
    assign wr_req    = (acc & mem_wr & (off == 3'd0) & (mem_dout != 8'h00)) | stop_wr;
    assign push_byte = (off == 3'd4) ? 8'h00 : mem_dout;

    assign tx_valid = ~empty;
    assign tx_data  = mem[rptr[DEPTH_LOG-1:0]];
    assign pop      = tx_valid & tx_ready;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept the byte.
    assign push = wr_req & (~full | pop);
    assign drop = wr_req & full & ~pop;

    assign count      = wptr - rptr;
    assign next_count = count + {{DEPTH_LOG{1'b0}}, push} - {{DEPTH_LOG{1'b0}}, pop};
    assign full_next  = (DEPTH - int'(next_count)) <= FULL_MARGIN;

    // FIFO pointer and storage update; the UART side drains regardless of rdy_in.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (push) begin
                mem[wptr[DEPTH_LOG-1:0]] <= push_byte;
                wptr                     <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    // Status flags: early-full warning, sticky overflow, stop request and completion.
    logic stop_req;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            io_buffer_full <= 1'b0;
            tx_overflow    <= 1'b0;
            stop_req       <= 1'b0;
            sim_done       <= 1'b0;
        end else begin
            io_buffer_full <= full_next;
            tx_overflow    <= tx_overflow | drop;
            stop_req       <= stop_req | stop_wr;
            sim_done       <= sim_done | (stop_req & empty & ~tx_valid);
        end
    end

    // Free-running cycle counter, independent of CPU stalls.
    logic [31:0] cyc;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cyc <= 32'h0;
        end else begin
            cyc <= cyc + 32'd1;
        end
    end

    // Read data select; the upper counter bytes come from the snapshot taken by the offset-4 read.
    logic [31:0] snap;
    logic [7:0]  rx_hold;
    logic        rx_hold_vld;
    logic [7:0]  rd_data;

    always_comb begin
        rd_data = 8'h00;
        case (off)
            3'd0:    rd_data = rx_hold_vld ? rx_hold : 8'h00;
            3'd4:    rd_data = cyc[7:0];
            3'd5:    rd_data = snap[15:8];
            3'd6:    rd_data = snap[23:16];
            3'd7:    rd_data = snap[31:24];
            default: rd_data = 8'h00;
        endcase
    end

    // Registered read return, counter snapshot and RX holding byte (a new RX byte wins over the clear).
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            io_rd_sel   <= 1'b0;
            io_din      <= 8'h00;
            snap        <= 32'h0;
            rx_hold     <= 8'h00;
            rx_hold_vld <= 1'b0;
        end else begin
            io_rd_sel <= rd;
            if (rd) begin
                io_din <= rd_data;
            end
            if (rd && (off == 3'd4)) begin
                snap <= cyc;
            end
            if (rx_valid) begin
                rx_hold     <= rx_data;
                rx_hold_vld <= 1'b1;
            end else if (rd && (off == 3'd0)) begin
                rx_hold_vld <= 1'b0;
            end
        end
    end

endmodule
